// File: rtl/mcpu5_prog_ctrl_if.sv
// Bus bundle for the mcpu5 program controller: CPU fetch, loader stream,
// program RAM port and captured CPU output.
interface mcpu5_prog_ctrl_if;
   logic [7:0] cpu_addr;
   logic [5:0] cpu_inst;
   logic       cpu_rst;
   logic       ld_start;
   logic       ld_valid;
   logic       ld_last;
   logic [5:0] ld_data;
   logic       ld_ready;
   logic [5:0] mem_addr;
   logic [5:0] mem_wdata;
   logic       mem_we;
   logic [5:0] mem_rdata;
   logic       out_valid;
   logic [7:0] out_data;
   logic [1:0] state;

   modport slave (
      input  cpu_addr, ld_start, ld_valid, ld_last, ld_data, mem_rdata,
      output cpu_inst, cpu_rst, ld_ready, mem_addr, mem_wdata, mem_we,
             out_valid, out_data, state
   );

   modport master (
      output cpu_addr, ld_start, ld_valid, ld_last, ld_data, mem_rdata,
      input  cpu_inst, cpu_rst, ld_ready, mem_addr, mem_wdata, mem_we,
             out_valid, out_data, state
   );
endinterface

// File: rtl/mcpu5_prog_ctrl.sv
// Program controller for mcpu5: streams a program into the single-port RAM,
// holds the CPU in reset while loading, then runs it and captures OUT values.
module mcpu5_prog_ctrl #(
   parameter logic [5:0] OUT_OPCODE = 6'b111011,
   parameter logic [5:0] RESET_INST = 6'b111001,
   parameter int         MAX_WORDS  = 64
) (
   input logic              clk,
   input logic              reset,
   mcpu5_prog_ctrl_if.slave bus
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_LOAD    = 2'd1;
   localparam logic [1:0] S_RELEASE = 2'd2;
   localparam logic [1:0] S_RUN     = 2'd3;
   localparam logic [5:0] LAST_ADDR = 6'(MAX_WORDS - 1);

   logic [1:0] state_q;
   logic [1:0] state_d;
   logic [5:0] wcnt;
   logic       wr_acc;
   logic       last_word;
   logic       run_ok;
   logic       out_pend_p1;
   logic       out_vld_p2;
   logic [7:0] out_data_p2;

   assign wr_acc    = (state_q == S_LOAD) && bus.ld_valid;
   assign last_word = bus.ld_last || (wcnt == LAST_ADDR);
   // Staying in RUN next cycle; anything else cancels an in-flight OUT capture.
   assign run_ok    = (state_q == S_RUN) && !bus.ld_start;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (bus.ld_start) state_d = S_LOAD;
         S_LOAD:    if (!bus.ld_start && wr_acc && last_word) state_d = S_RELEASE;
         S_RELEASE: state_d = bus.ld_start ? S_LOAD : S_RUN;
         default:   if (bus.ld_start) state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         wcnt    <= '0;
      end else begin
         state_q <= state_d;
         if (bus.ld_start)
            wcnt <= '0;
         else if (wr_acc)
            wcnt <= wcnt + 6'd1;
      end
   end

   // p1: OUT seen last cycle; p2: cpu_addr captured, valid pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_pend_p1 <= 1'b0;
         out_vld_p2  <= 1'b0;
         out_data_p2 <= '0;
      end else begin
         out_pend_p1 <= run_ok && (bus.cpu_inst == OUT_OPCODE);
         out_vld_p2  <= out_pend_p1 && run_ok;
         if (out_pend_p1 && run_ok)
            out_data_p2 <= bus.cpu_addr;
      end
   end

   always_comb begin
      case (state_q)
         S_LOAD:  bus.mem_addr = wcnt;
         S_RUN:   bus.mem_addr = bus.cpu_addr[5:0];
         default: bus.mem_addr = '0;
      endcase
   end

   assign bus.ld_ready  = (state_q == S_LOAD);
   assign bus.mem_we    = wr_acc;
   assign bus.mem_wdata = wr_acc ? bus.ld_data : '0;
   assign bus.cpu_rst   = (state_q != S_RUN);
   assign bus.cpu_inst  = (state_q == S_RUN) ? bus.mem_rdata : RESET_INST;
   assign bus.out_valid = out_vld_p2;
   assign bus.out_data  = out_data_p2;
   assign bus.state     = state_q;

endmodule
